game_sequencer: RTL and testbench
=================================

# game_sequencer

Level sequencer for the two-lane rhythm game. It sits between the board buttons and the `main_game` core and drives all of that core's configuration inputs: the reset, mode, both 32-bit note patterns and the beat period `diff`. It walks the player through idle, countdown, play and pause across four fixed levels, and ends in win or game-over. It speeds up with each level and aborts when the miss count exceeds a limit.

## Interface
Parameters:
- `BASE_DIFF`, 23'd4000000: beat period, in clk cycles, for level 0.
- `DIFF_STEP`, 23'd500000: period reduction applied per level.
- `MIN_DIFF`, 23'd1000000: floor for the beat period.
- `CD_BEATS`, 2'd3: countdown length in beats (1–3).
- `TAIL_BEATS`, 4'd2: extra beats after the 32 note beats, so the last notes can scroll out.
- `MAX_MISSES`, 8'd10: game over once `num_misses` exceeds this value.
- `MODE_RUN`, 3'd4: mode code meaning the core runs.
- `MODE_HOLD`, 3'd0: mode code meaning the core freezes.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: start button, synchronized level.
- `pause` in 1: pause button, synchronized level.
- `num_misses` in 8: miss count from the core.
- `game_rst` out 1: active-high reset to the core. Top-level inverts it into `n_rst`.
- `mode` out 3: mode code to the core.
- `notes1` out 32: lane-1 pattern for the current level.
- `notes2` out 32: lane-2 pattern for the current level.
- `diff` out 23: beat period for the current level.
- `level` out 2: current level index.
- `countdown` out 2: beats left in the countdown; 0 outside COUNTDOWN.
- `win` out 1: high in WIN.
- `over` out 1: high in OVER.

## Operation
- Both `start` and `pause` are rising-edge detected internally. A held level produces one event.
- Song ROM, indexed by level, gives (`notes1`, `notes2`):
  - level 0: AAAAAAAA / CCCCCCCC
  - level 1: 92492492 / 24924924
  - level 2: F0F0F0F0 / 0F0F0F0F
  - level 3: FFFF0000 / 0000FFFF
- Beat period: `diff = max(BASE_DIFF − level·DIFF_STEP, MIN_DIFF)`.
  - Compute in 26-bit unsigned arithmetic and clamp before truncating to 23 bits.
  - A negative intermediate result clamps to `MIN_DIFF`.
- Beat timer: a 23-bit cycle counter runs only in COUNTDOWN and PLAY.
  - On reaching `diff`−1 it wraps to 0 and emits a one-cycle beat pulse.
  - It holds its value in PAUSE and clears on every state entry, except PAUSE→PLAY, which resumes.
- Beat index: a 6-bit counter incremented by each beat pulse in PLAY. It is cleared on LOAD.
- States and transitions:
  - **IDLE**:
    - `game_rst`=1, `mode`=MODE_HOLD.
    - start → LOAD with `level`=0.
  - **LOAD** (one cycle):
    - `game_rst`=1.
    - Latches `notes1`, `notes2` and `diff` for `level`.
    - Clears the beat timer and beat index.
    - → COUNTDOWN.
  - **COUNTDOWN**:
    - `game_rst`=0, `mode`=MODE_HOLD.
    - `countdown` loads `CD_BEATS` on entry and decrements on each beat pulse.
    - Beat pulse while `countdown`=1 → PLAY.
    - pause is ignored.
  - **PLAY**:
    - `mode`=MODE_RUN.
    - `num_misses` > MAX_MISSES → OVER. This has top priority.
    - Else, beat pulse that makes the beat index equal 32+TAIL_BEATS → advance:
      - `level`=3 → WIN;
      - otherwise `level`+1 and → LOAD.
    - Else pause → PAUSE.
  - **PAUSE**:
    - `mode`=MODE_HOLD; timer frozen.
    - pause → PLAY.
    - start → IDLE (quit).
  - **WIN** / **OVER**:
    - `mode`=MODE_HOLD, `game_rst`=0, so the final score stays visible.
    - start → LOAD with `level`=0.
- Simultaneous events:
  - Miss abort beats the song-end advance.
  - In PAUSE, if start and pause edges arrive in the same cycle, start wins.
- The core sees a `game_rst` pulse of at least one cycle (LOAD) before every level, so its hit and miss counters restart per level.

## Timing
- Reset values:
  - state IDLE;
  - `game_rst`=1, `mode`=MODE_HOLD;
  - `notes1`=`notes2`=0;
  - `diff`=BASE_DIFF;
  - `level`=0, `countdown`=0;
  - `win`=`over`=0;
  - timer, beat index and edge-detect registers all 0.
- All outputs are registered and change on the clk edge after the triggering condition.
- Start-to-play latency: 1 cycle (edge) + 1 (LOAD) + CD_BEATS·`diff` cycles.
- Level play length: (32+TAIL_BEATS)·`diff` cycles of PLAY time, excluding PAUSE time.
- Reset asserted mid-level returns to IDLE on the next edge with the reset values above. No partial state survives.

## Test plan
Set BASE_DIFF=10, DIFF_STEP=3, MIN_DIFF=5, CD_BEATS=3, TAIL_BEATS=2 and MAX_MISSES=2 for all scenarios.
- **Reset:** assert reset → all outputs at reset values. Hold `start` high for 5 cycles → exactly one LOAD. `game_rst` falls the next cycle, and `countdown` reads 3, 2, 1 at 10-cycle spacing.
- **Level sequence:** start, no misses, full level-0 play → PLAY lasts 340 cycles. Then LOAD occurs with `level`=1, `diff`=7, `notes1`=92492492. Level 2 → `diff`=5; level 3 → `diff`=5 (clamped). After level 3 completes → `win`=1.
- **Miss abort:** during PLAY drive `num_misses`=3 → `over`=1 next cycle and `mode`=MODE_HOLD. Then a start edge → LOAD, `level`=0, `over`=0.
- **Pause:** pause edge at beat 5 + 4 cycles → `mode`=MODE_HOLD and the timer is frozen for 100 cycles. A second pause edge resumes, and the level ends exactly 340 PLAY cycles after entry.
- **Simultaneous events:**
  - In PAUSE, assert start and pause edges in the same cycle → IDLE.
  - Raise `num_misses`=3 in the same cycle as the final beat pulse → OVER, with no advance to LOAD.
- **Mid-game reset:** assert reset during level 2 COUNTDOWN → IDLE, `level`=0, `diff`=10, `game_rst`=1 on the next edge.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: level FSM driving the rhythm-game core's reset, mode, note patterns and beat period.
module game_sequencer #(
  parameter logic [22:0] BASE_DIFF  = 23'd4000000,
  parameter logic [22:0] DIFF_STEP  = 23'd500000,
  parameter logic [22:0] MIN_DIFF   = 23'd1000000,
  parameter logic [1:0]  CD_BEATS   = 2'd3,
  parameter logic [3:0]  TAIL_BEATS = 4'd2,
  parameter logic [7:0]  MAX_MISSES = 8'd10,
  parameter logic [2:0]  MODE_RUN   = 3'd4,
  parameter logic [2:0]  MODE_HOLD  = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [7:0]  num_misses,
  output logic        game_rst,
  output logic [2:0]  mode,
  output logic [31:0] notes1,
  output logic [31:0] notes2,
  output logic [22:0] diff,
  output logic [1:0]  level,
  output logic [1:0]  countdown,
  output logic        win,
  output logic        over
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CD = 3'd2, S_PLAY = 3'd3,
                         S_PAUSE = 3'd4, S_WIN = 3'd5, S_OVER = 3'd6;
  localparam logic [5:0] END_BEAT = 6'd32 + {2'b00, TAIL_BEATS};
  logic [2:0] state, nxt;
  logic start_q, pause_q, start_e, pause_e, run, beat, song_end, clr;
  logic [22:0] timer, diff_lvl;
  logic [5:0] bidx;
  logic [25:0] diff_raw;
  logic [31:0] rom1, rom2;
  assign start_e  = start & ~start_q;
  assign pause_e  = pause & ~pause_q;
  assign run      = state == S_CD || state == S_PLAY;
  assign beat     = run && timer == diff - 23'd1;
  assign song_end = state == S_PLAY && beat && bidx + 6'd1 == END_BEAT;
  // wrapped (negative) results land in the upper half, caught by bit 25
  assign diff_raw = {3'b000, BASE_DIFF} - {24'd0, level} * {3'b000, DIFF_STEP};
  assign diff_lvl = (diff_raw[25] || diff_raw < {3'b000, MIN_DIFF}) ? MIN_DIFF : diff_raw[22:0];
  assign rom1 = level == 2'd0 ? 32'hAAAAAAAA : level == 2'd1 ? 32'h92492492 :
                level == 2'd2 ? 32'hF0F0F0F0 : 32'hFFFF0000;
  assign rom2 = level == 2'd0 ? 32'hCCCCCCCC : level == 2'd1 ? 32'h24924924 :
                level == 2'd2 ? 32'h0F0F0F0F : 32'h0000FFFF;
  // the timer survives a pause round-trip; any other state change restarts it
  assign clr = nxt != state && !(state == S_PLAY && nxt == S_PAUSE) && !(state == S_PAUSE && nxt == S_PLAY);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start_e ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_CD;
      S_CD:    nxt = (beat && countdown == 2'd1) ? S_PLAY : S_CD;
      S_PLAY:  nxt = num_misses > MAX_MISSES ? S_OVER :
                     song_end ? (level == 2'd3 ? S_WIN : S_LOAD) :
                     pause_e ? S_PAUSE : S_PLAY;
      S_PAUSE: nxt = start_e ? S_IDLE : pause_e ? S_PLAY : S_PAUSE;
      S_WIN, S_OVER: nxt = start_e ? S_LOAD : state;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      timer     <= '0;
      bidx      <= '0;
      game_rst  <= 1'b1;
      mode      <= MODE_HOLD;
      notes1    <= '0;
      notes2    <= '0;
      diff      <= BASE_DIFF;
      level     <= '0;
      countdown <= '0;
      win       <= 1'b0;
      over      <= 1'b0;
    end else begin
      state     <= nxt;
      start_q   <= start;
      pause_q   <= pause;
      timer     <= (clr || beat) ? '0 : run ? timer + 23'd1 : timer;
      bidx      <= state == S_LOAD ? '0 : (state == S_PLAY && beat) ? bidx + 6'd1 : bidx;
      game_rst  <= nxt == S_IDLE || nxt == S_LOAD;
      mode      <= nxt == S_PLAY ? MODE_RUN : MODE_HOLD;
      notes1    <= state == S_LOAD ? rom1 : notes1;
      notes2    <= state == S_LOAD ? rom2 : notes2;
      diff      <= state == S_LOAD ? diff_lvl : diff;
      level     <= nxt == S_LOAD && state != S_LOAD ? (state == S_PLAY ? level + 2'd1 : 2'd0) : level;
      countdown <= nxt != S_CD ? 2'd0 : state != S_CD ? CD_BEATS : beat ? countdown - 2'd1 : countdown;
      win       <= nxt == S_WIN;
      over      <= nxt == S_OVER;
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of level flow, countdown, pause, abort and reset.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset, start, pause;
  logic [7:0] num_misses;
  logic game_rst, win, over;
  logic [2:0] mode;
  logic [31:0] notes1, notes2;
  logic [22:0] diff;
  logic [1:0] level, countdown;
  int checks = 0, errors = 0, n;
  game_sequencer #(
    .BASE_DIFF(23'd10), .DIFF_STEP(23'd3), .MIN_DIFF(23'd5), .CD_BEATS(2'd3),
    .TAIL_BEATS(4'd2), .MAX_MISSES(8'd2), .MODE_RUN(3'd4), .MODE_HOLD(3'd0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .num_misses(num_misses),
    .game_rst(game_rst), .mode(mode), .notes1(notes1), .notes2(notes2), .diff(diff),
    .level(level), .countdown(countdown), .win(win), .over(over)
  );
  always #5 clk = ~clk;
  task tick;
    @(negedge clk);
  endtask
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task press_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task wait_play(input int bound);
    int k;
    k = 0;
    while (mode != 3'd4 && k < bound) begin
      tick;
      k++;
    end
    chk("reach_play", {29'd0, mode}, 32'd4);
  endtask
  task play_len(output int len);
    len = 0;
    while (mode == 3'd4 && len < 1000) begin
      len++;
      tick;
    end
  endtask
  task run_level(input string tag, input int exp_len);
    int len;
    wait_play(200);
    play_len(len);
    chk(tag, len, exp_len);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; num_misses = 8'd0;
    repeat (3) tick;
    chk("rst_game_rst", {31'd0, game_rst}, 32'd1);
    chk("rst_mode", {29'd0, mode}, 32'd0);
    chk("rst_notes1", notes1, 32'd0);
    chk("rst_notes2", notes2, 32'd0);
    chk("rst_diff", {9'd0, diff}, 32'd10);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_cd", {30'd0, countdown}, 32'd0);
    chk("rst_win_over", {30'd0, win, over}, 32'd0);
    reset = 1'b0;
    tick;
    chk("idle_game_rst", {31'd0, game_rst}, 32'd1);
    start = 1'b1;
    tick;
    chk("load_game_rst", {31'd0, game_rst}, 32'd1);
    tick;
    chk("cd_game_rst", {31'd0, game_rst}, 32'd0);
    chk("cd_first", {30'd0, countdown}, 32'd3);
    chk("cd_notes1", notes1, 32'hAAAAAAAA);
    chk("cd_notes2", notes2, 32'hCCCCCCCC);
    repeat (3) tick;
    start = 1'b0;
    repeat (6) tick;
    chk("cd_3_end", {30'd0, countdown}, 32'd3);
    chk("one_load", {31'd0, game_rst}, 32'd0);
    tick;
    chk("cd_2", {30'd0, countdown}, 32'd2);
    repeat (10) tick;
    chk("cd_1", {30'd0, countdown}, 32'd1);
    repeat (9) tick;
    chk("cd_1_end", {29'd0, mode}, 32'd0);
    tick;
    chk("play_mode", {29'd0, mode}, 32'd4);
    chk("play_cd0", {30'd0, countdown}, 32'd0);
    play_len(n);
    chk("play_len_l0", n, 32'd340);
    chk("l1_load", {31'd0, game_rst}, 32'd1);
    chk("l1_level", {30'd0, level}, 32'd1);
    tick;
    chk("l1_diff", {9'd0, diff}, 32'd7);
    chk("l1_notes1", notes1, 32'h92492492);
    chk("l1_notes2", notes2, 32'h24924924);
    run_level("play_len_l1", 238);
    chk("l2_level", {30'd0, level}, 32'd2);
    tick;
    chk("l2_diff", {9'd0, diff}, 32'd5);
    chk("l2_notes1", notes1, 32'hF0F0F0F0);
    run_level("play_len_l2", 170);
    chk("l3_level", {30'd0, level}, 32'd3);
    tick;
    chk("l3_diff", {9'd0, diff}, 32'd5);
    chk("l3_notes2", notes2, 32'h0000FFFF);
    run_level("play_len_l3", 170);
    chk("win", {31'd0, win}, 32'd1);
    chk("win_mode", {29'd0, mode}, 32'd0);
    chk("win_game_rst", {31'd0, game_rst}, 32'd0);
    press_start;
    chk("restart_level", {30'd0, level}, 32'd0);
    chk("restart_win", {31'd0, win}, 32'd0);
    wait_play(100);
    repeat (7) tick;
    num_misses = 8'd3;
    tick;
    chk("abort_over", {31'd0, over}, 32'd1);
    chk("abort_mode", {29'd0, mode}, 32'd0);
    num_misses = 8'd0;
    tick;
    press_start;
    chk("abort_restart_load", {31'd0, game_rst}, 32'd1);
    chk("abort_restart_level", {30'd0, level}, 32'd0);
    chk("abort_restart_over", {31'd0, over}, 32'd0);
    wait_play(100);
    n = 0;
    while (mode == 3'd4 && n < 54) begin
      n++;
      if (n == 54) pause = 1'b1;
      tick;
    end
    chk("pause_mode", {29'd0, mode}, 32'd0);
    pause = 1'b0;
    repeat (99) tick;
    chk("pause_hold_mode", {29'd0, mode}, 32'd0);
    chk("pause_game_rst", {31'd0, game_rst}, 32'd0);
    pause = 1'b1;
    tick;
    pause = 1'b0;
    chk("resume_mode", {29'd0, mode}, 32'd4);
    play_len(n);
    chk("pause_play_rest", n, 32'd286);
    chk("pause_next_level", {30'd0, level}, 32'd1);
    wait_play(100);
    repeat (5) tick;
    pause = 1'b1;
    tick;
    pause = 1'b0;
    chk("sim_paused", {29'd0, mode}, 32'd0);
    repeat (3) tick;
    start = 1'b1;
    pause = 1'b1;
    tick;
    chk("sim_idle", {31'd0, game_rst}, 32'd1);
    chk("sim_mode", {29'd0, mode}, 32'd0);
    tick;
    chk("sim_idle_hold", {31'd0, game_rst}, 32'd1);
    start = 1'b0;
    pause = 1'b0;
    tick;
    press_start;
    chk("lastbeat_level0", {30'd0, level}, 32'd0);
    wait_play(100);
    n = 0;
    while (mode == 3'd4 && n < 340) begin
      n++;
      if (n == 340) num_misses = 8'd3;
      tick;
    end
    chk("lastbeat_over", {31'd0, over}, 32'd1);
    chk("lastbeat_no_load", {31'd0, game_rst}, 32'd0);
    chk("lastbeat_level", {30'd0, level}, 32'd0);
    num_misses = 8'd0;
    tick;
    press_start;
    run_level("mid_l0", 340);
    run_level("mid_l1", 238);
    chk("mid_l2_level", {30'd0, level}, 32'd2);
    tick;
    chk("mid_l2_cd", {30'd0, countdown}, 32'd3);
    repeat (4) tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_game_rst", {31'd0, game_rst}, 32'd1);
    chk("mid_rst_level", {30'd0, level}, 32'd0);
    chk("mid_rst_diff", {9'd0, diff}, 32'd10);
    chk("mid_rst_cd", {30'd0, countdown}, 32'd0);
    chk("mid_rst_notes1", notes1, 32'd0);
    reset = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
